// File: rtl/rtds_tx_pre.sv
// rtds_tx_pre: host-to-Aurora transmit framer. Accepts host AXI-Stream
// frames, optionally appends a trailing 32-bit sequence word, truncates
// over-length frames, and reports per-frame word counts.
module rtds_tx_pre #(
  parameter int unsigned MAX_WORDS = 64,
  parameter logic [31:0] SEQ_INIT  = 32'h0000_0000
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_areset,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        ctrl_append_seq_en,
  output logic [15:0] stat_cnt_pkts,
  output logic        stat_cnt_pkts_rdy,
  output logic [31:0] stat_seq_num,
  output logic        stat_trunc_err
);

  localparam int          DATA_W = 32;
  localparam logic [15:0] MAX_W  = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_SEQ  = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state;
  logic        mode;
  logic        trunc;
  logic [15:0] wcnt;

  logic        slot_free;
  logic        acc;
  logic [15:0] wcnt_nxt;
  logic        frame_mode;
  logic        at_max;
  logic        frame_end;
  logic        forced;

  // Sequence numbers wrap modulo 2^32.
  function automatic logic [DATA_W-1:0] seq_next(input logic [DATA_W-1:0] s);
    return s + 1'b1;
  endfunction

  // The output register can take a new word when empty or being drained.
  assign slot_free = ~m_axis_tvalid | m_axis_tready;

  // Dropped beats never touch the output register, so ST_DROP accepts freely.
  assign s_axis_tready = (state == ST_DROP) | (slot_free & (state != ST_SEQ));
  assign acc           = s_axis_tvalid & s_axis_tready;

  // Frame-end decode for the beat currently offered by the host.
  always_comb begin
    wcnt_nxt   = (state == ST_IDLE) ? 16'd1 : wcnt + 16'd1;
    frame_mode = (state == ST_IDLE) ? ctrl_append_seq_en : mode;
    at_max     = (wcnt_nxt == MAX_W);
    frame_end  = s_axis_tlast | at_max;
    forced     = at_max & ~s_axis_tlast;
  end

  // Framing FSM, output register and status registers.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state             <= ST_IDLE;
      mode              <= 1'b0;
      trunc             <= 1'b0;
      wcnt              <= 16'd0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tlast      <= 1'b0;
      stat_cnt_pkts     <= 16'd0;
      stat_cnt_pkts_rdy <= 1'b0;
      stat_seq_num      <= SEQ_INIT;
      stat_trunc_err    <= 1'b0;
    end else begin
      // Output stage: a drained slot empties unless reloaded below.
      if (slot_free) m_axis_tvalid <= 1'b0;

      case (state)
        ST_IDLE, ST_DATA: begin
          if (acc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= frame_end & ~frame_mode;
            wcnt          <= wcnt_nxt;
            if (state == ST_IDLE) begin
              mode              <= ctrl_append_seq_en;
              stat_cnt_pkts_rdy <= 1'b0;
            end
            if (frame_end) begin
              if (frame_mode) begin
                trunc <= forced;
                state <= ST_SEQ;
              end else begin
                stat_cnt_pkts     <= wcnt_nxt;
                stat_cnt_pkts_rdy <= 1'b1;
                state             <= forced ? ST_DROP : ST_IDLE;
              end
              if (forced) stat_trunc_err <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end

        ST_SEQ: begin
          if (slot_free) begin
            m_axis_tvalid     <= 1'b1;
            m_axis_tdata      <= stat_seq_num;
            m_axis_tlast      <= 1'b1;
            stat_cnt_pkts     <= wcnt + 16'd1;
            stat_cnt_pkts_rdy <= 1'b1;
            stat_seq_num      <= seq_next(stat_seq_num);
            state             <= trunc ? ST_DROP : ST_IDLE;
          end
        end

        ST_DROP: begin
          if (acc && s_axis_tlast) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtds_tx_pre.sv
// Testbench for rtds_tx_pre: random frames and backpressure checked against
// a frame-level reference model.
module tb_rtds_tx_pre;

  localparam int          MAXW  = 4;
  localparam logic [31:0] SINIT = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        ctrl_en = 1'b0;
  logic [15:0] st_cnt;
  logic        st_rdy;
  logic [31:0] st_seq;
  logic        st_trunc;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [31:0] seq_model = SINIT;
  bit          trunc_model = 1'b0;
  int          cnt_model = 0;
  bit          ignore_out = 1'b0;
  bit          rdy_always = 1'b0;

  rtds_tx_pre #(.MAX_WORDS(MAXW), .SEQ_INIT(SINIT)) dut (
    .m_axis_aclk       (clk),
    .m_axis_areset     (rst),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tdata      (s_tdata),
    .s_axis_tlast      (s_tlast),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tdata      (m_tdata),
    .m_axis_tlast      (m_tlast),
    .ctrl_append_seq_en(ctrl_en),
    .stat_cnt_pkts     (st_cnt),
    .stat_cnt_pkts_rdy (st_rdy),
    .stat_seq_num      (st_seq),
    .stat_trunc_err    (st_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sink backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: scoreboard compare and stall-stability check.
  initial begin
    logic        held_v;
    logic [31:0] held_d;
    logic        held_l;
    logic [32:0] e;
    held_v = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && held_v && m_tvalid) begin
        chk("stall_data", m_tdata, held_d);
        chk("stall_last", 32'(m_tlast), 32'(held_l));
      end
      if (!rst && m_tvalid && m_tready && !ignore_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_tdata, 32'hDEAD_BEEF ^ m_tdata ^ 32'h1);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e[31:0]);
          chk("out_last", 32'(m_tlast), 32'(e[32]));
        end
      end
      held_v = !rst && m_tvalid && !m_tready;
      held_d = m_tdata;
      held_l = m_tlast;
    end
  end

  // Offer one host beat (starting just after a rising edge) until accepted.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 200) begin
        chk("s_ready_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Send one frame, predict its output, then check the status after it drains.
  task automatic send_frame(input int len, input bit mode);
    logic [31:0] d[];
    int          eff;
    int          n;
    d = new[len];
    foreach (d[i]) d[i] = $urandom;
    eff = (len > MAXW) ? MAXW : len;
    for (int i = 0; i < eff; i++)
      exp_q.push_back({(!mode && (i == eff - 1)), d[i]});
    if (mode) begin
      exp_q.push_back({1'b1, seq_model});
      seq_model = seq_model + 32'd1;
    end
    cnt_model = eff + (mode ? 1 : 0);
    if (len > MAXW) trunc_model = 1'b1;

    ctrl_en = mode;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_beat(d[i], (i == len - 1));
      if (i == 0) begin
        chk("rdy_after_first", 32'(st_rdy), 32'(len == 1 && !mode));
        ctrl_en = $urandom_range(0, 1);
      end
    end

    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("cnt_pkts", 32'(st_cnt), 32'(cnt_model));
    chk("cnt_rdy", 32'(st_rdy), 32'd1);
    chk("seq_num", st_seq, seq_model);
    chk("trunc_err", 32'(st_trunc), 32'(trunc_model));
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_cnt", 32'(st_cnt), 32'd0);
    chk("rst_rdy", 32'(st_rdy), 32'd0);
    chk("rst_seq", st_seq, SINIT);
    chk("rst_trunc", 32'(st_trunc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    rdy_always = 1'b1;
    send_frame(3, 1'b1);
    send_frame(2, 1'b0);
    rdy_always = 1'b0;
    send_frame(4, 1'b1);
    send_frame(1, 1'b1);
    send_frame(6, 1'b1);
    send_frame(5, 1'b0);
    send_frame(1, 1'b0);
    for (int f = 0; f < 24; f++)
      send_frame($urandom_range(1, 7), 1'($urandom_range(0, 1)));

    // Abandon a frame part-way with an asynchronous reset.
    ignore_out = 1'b1;
    ctrl_en = 1'b1;
    send_beat(32'h1111_0001, 1'b0);
    send_beat(32'h1111_0002, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_m_tdata", m_tdata, 32'd0);
    chk("arst_m_tlast", 32'(m_tlast), 32'd0);
    chk("arst_cnt", 32'(st_cnt), 32'd0);
    chk("arst_rdy", 32'(st_rdy), 32'd0);
    chk("arst_seq", st_seq, SINIT);
    chk("arst_trunc", 32'(st_trunc), 32'd0);
    exp_q.delete();
    seq_model   = SINIT;
    trunc_model = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ignore_out = 1'b0;

    send_frame(1, 1'b1);
    send_frame(1, 1'b1);
    send_frame(1, 1'b1);
    send_frame(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtds_tx_pre.md
Name: rtds_tx_pre

Overview:
Transmit-side counterpart of the RTDS receive post-processing stage. Takes frames from the host over an AXI-Stream slave with backpressure and appends a trailing 32-bit sequence number. It drives the result, with a correct tlast, into the Aurora TX AXI-Stream toward RTDS. It also reports per-frame word counts and guards against over-length frames.

Parameters:
MAX_WORDS, 64, maximum data words per frame, excluding the sequence word; range 1..65534
SEQ_INIT, 32'h0000_0000, sequence number used for the first frame after reset

Ports:
m_axis_aclk  input  1  single clock for the whole block
m_axis_areset  input  1  asynchronous, active-high reset
s_axis_tvalid  input  1  host data valid
s_axis_tready  output  1  block accepts host data
s_axis_tdata  input  32  host data word
s_axis_tlast  input  1  last host word of frame
m_axis_tvalid  output  1  Aurora TX data valid (registered)
m_axis_tready  input  1  Aurora TX ready
m_axis_tdata  output  32  Aurora TX data (registered)
m_axis_tlast  output  1  Aurora TX last (registered)
ctrl_append_seq_en  input  1  1 = append sequence word; 0 = transparent pass-through
stat_cnt_pkts  output  16  words sent in the last completed frame, including the sequence word if appended
stat_cnt_pkts_rdy  output  1  stat_cnt_pkts valid; cleared on the first beat of the next frame
stat_seq_num  output  32  sequence number the next frame will carry
stat_trunc_err  output  1  sticky; set on a forced frame end; cleared only by reset

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock deassert): all outputs 0, except stat_seq_num = SEQ_INIT. State = ST_IDLE. Word counter = 0. A partial frame is abandoned, nothing is flushed, and the sequence restarts at SEQ_INIT.
- Output stage: a one-deep register.
  - "Slot free" = ~m_axis_tvalid | m_axis_tready.
  - Accepted host beats appear on m_axis_* one cycle later.
  - m_axis_tdata/tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- s_axis_tready = slot free & (state != ST_SEQ). It is combinational from m_axis_tready and state only, never from s_axis_tvalid.
- FSM:
  - ST_IDLE: on an accepted beat, latch ctrl_append_seq_en as the frame mode (held for the whole frame), clear stat_cnt_pkts_rdy, set word counter = 1, go to ST_DATA. If that beat is also the frame end, apply the ST_DATA end rules in the same cycle.
  - ST_DATA: each accepted beat increments the word counter. Frame end = s_axis_tlast, or word counter reaching MAX_WORDS.
    - On frame end with mode=1: the beat goes out with m_axis_tlast=0; go to ST_SEQ.
    - On frame end with mode=0: the beat goes out with m_axis_tlast=1; publish the count; go to ST_IDLE.
    - Forced end (MAX_WORDS reached without s_axis_tlast): set stat_trunc_err. Further host beats up to and including the host tlast are accepted and dropped (ST_DROP), with no output and no count.
  - ST_SEQ: when the slot is free, load m_axis_tdata = stat_seq_num with m_axis_tlast=1. In that cycle: publish the count (data words + 1), increment stat_seq_num, go to ST_IDLE, or to ST_DROP if truncated.
  - ST_DROP: s_axis_tready=1. Stay until an accepted beat with s_axis_tlast, then go to ST_IDLE.
- Arithmetic:
  - stat_seq_num increments by 1 modulo 2^32 (FFFF_FFFF wraps to 0000_0000).
  - It increments only when a sequence word is emitted.
  - The word counter is 16 bits; MAX_WORDS ≤ 65534 guarantees no overflow.
- Status timing: stat_cnt_pkts and stat_cnt_pkts_rdy update in the cycle the last output word is loaded into the output register, not when it handshakes out.
- ctrl_append_seq_en changes mid-frame have no effect until the next ST_IDLE acceptance.
- s_axis_tvalid high with s_axis_tlast in ST_IDLE is a one-word frame: with mode=1 the output is 2 words, count 2.

Test Plan:
- Reset, mode=1; send 3-word frame A1,A2,A3 with m_axis_tready=1 -> output A1,A2,A3,00000000, tlast only on the 4th word; stat_cnt_pkts=4, rdy=1; stat_seq_num=1.
- Mode=0; send 2-word frame -> output identical 2 words, tlast on the 2nd word; count=2; stat_seq_num unchanged.
- Mode=1; m_axis_tready toggles 1,0,0,1 during a 4-word frame -> no loss or duplication; data stable while stalled; s_axis_tready=0 during the ST_SEQ cycle.
- MAX_WORDS=4; send 6-word frame, mode=1 -> output 4 words plus seq word (tlast); words 5–6 accepted and dropped; stat_trunc_err=1; count=5.
- Force stat_seq_num to FFFFFFFF via SEQ_INIT; send two 1-word frames -> seq words FFFFFFFF then 00000000; each count=2.
- Assert m_axis_areset mid-frame after 2 words -> all outputs 0 immediately; next frame's seq word = SEQ_INIT; stat_trunc_err=0.
